harris_corner_tracker: RTL and testbench

//  Downstream consumer of the per-pixel signed Harris response stream.

---
 rtl/harris_corner_tracker.sv | 155 +++++++++++++++
 tb/tb_harris_corner_tracker.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harris_corner_tracker.sv
// Harris response stream consumer: raster tracking, per-pixel corner flags,
// per-frame corner count and strongest-corner capture with a one-cycle summary pulse.
module harris_corner_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int LAG      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                frame_start,
  input  logic signed [17:0]  harris_feature,
  input  logic signed [17:0]  threshold,
  output logic                corner_flag,
  output logic [X_W-1:0]      corner_x,
  output logic [Y_W-1:0]      corner_y,
  output logic signed [17:0]  best_feature,
  output logic [X_W-1:0]      best_x,
  output logic [Y_W-1:0]      best_y,
  output logic [15:0]         corner_count,
  output logic                result_valid,
  output logic                busy
);

  localparam logic [X_W-1:0]     X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [X_W-1:0]     X_MIN    = X_W'(2 * LAG);
  localparam logic [Y_W-1:0]     Y_MIN    = Y_W'(2 * LAG);
  localparam logic [X_W-1:0]     X_LAG    = X_W'(LAG);
  localparam logic [Y_W-1:0]     Y_LAG    = Y_W'(LAG);
  localparam logic signed [17:0] FEAT_MIN = 18'sh20000;
  localparam logic [15:0]        CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [X_W-1:0]        r_cx;
  logic [Y_W-1:0]        r_cy;
  logic signed [17:0]    r_runMax;
  logic [X_W-1:0]        r_runX;
  logic [Y_W-1:0]        r_runY;
  logic [15:0]           r_runCount;

  logic                  w_consume;
  logic                  w_inRegion;
  logic                  w_isCorner;
  logic                  w_newMax;
  logic                  w_lastSample;
  logic [X_W-1:0]        w_centreX;
  logic [Y_W-1:0]        w_centreY;

  // frame_start outranks clk_en, so a strobe in the same cycle is dropped.
  assign w_consume    = (r_state == ST_SCAN) && clk_en && !frame_start;
  assign w_inRegion   = (r_cx >= X_MIN) && (r_cy >= Y_MIN);
  assign w_isCorner   = w_inRegion && (harris_feature >= threshold);
  assign w_newMax     = w_inRegion && (harris_feature > r_runMax);
  assign w_lastSample = (r_cx == X_LAST) && (r_cy == Y_LAST);
  assign w_centreX    = r_cx - X_LAG;
  assign w_centreY    = r_cy - Y_LAG;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_runMax    <= '0;
      r_runX      <= '0;
      r_runY      <= '0;
      r_runCount  <= '0;
      corner_flag <= 1'b0;
      corner_x    <= '0;
      corner_y    <= '0;
    end else if (frame_start) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_runMax   <= FEAT_MIN;
      r_runX     <= '0;
      r_runY     <= '0;
      r_runCount <= '0;
    end else if (w_consume) begin
      corner_flag <= w_isCorner;
      corner_x    <= w_inRegion ? w_centreX : '0;
      corner_y    <= w_inRegion ? w_centreY : '0;

      if (w_isCorner && (r_runCount != CNT_MAX)) begin
        r_runCount <= r_runCount + 16'd1;
      end

      // Strict compare keeps the earliest position in raster order on ties.
      if (w_newMax) begin
        r_runMax <= harris_feature;
        r_runX   <= w_centreX;
        r_runY   <= w_centreY;
      end

      if (r_cx == X_LAST) begin
        r_cx <= '0;
        r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + Y_W'(1);
      end else begin
        r_cx <= r_cx + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      best_feature <= '0;
      best_x       <= '0;
      best_y       <= '0;
      corner_count <= '0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state <= ST_SCAN;
            busy    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_consume && w_lastSample) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
          end
        end
        ST_DONE: begin
          result_valid <= 1'b1;
          best_feature <= r_runMax;
          best_x       <= r_runX;
          best_y       <= r_runY;
          corner_count <= r_runCount;
          if (frame_start) begin
            r_state <= ST_SCAN;
            busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harris_corner_tracker.sv
// Scoreboard bench for harris_corner_tracker: a small-raster instance for functional
// scenarios and a larger raster instance that drives the corner count into saturation.
module tb_harris_corner_tracker;

  localparam int H   = 8;
  localparam int V   = 6;
  localparam int LAG = 2;
  localparam int BH  = 260;
  localparam int BV  = 260;

  typedef struct {
    int flag;
    int x;
    int y;
  } sampleExp_t;

  typedef struct {
    int best;
    int bx;
    int by;
    int count;
  } resultExp_t;

  logic clk = 1'b0;
  logic reset;

  logic               clkEn, frameStart, sampleStrobe;
  logic signed [17:0] feature, threshold;
  logic               cornerFlag, resultValid, busy;
  logic [9:0]         cornerX, cornerY, bestX, bestY;
  logic signed [17:0] bestFeature;
  logic [15:0]        cornerCount;

  logic               bigClkEn, bigFrameStart;
  logic signed [17:0] bigFeature, bigThreshold;
  logic               bigFlag, bigValid, bigBusy;
  logic [9:0]         bigCx, bigCy, bigBx, bigBy;
  logic signed [17:0] bigBest;
  logic [15:0]        bigCount;

  sampleExp_t sampleQ[$];
  resultExp_t resultQ[$];
  resultExp_t bigQ[$];
  int         frameData[V][H];
  int         checks = 0;
  int         fails  = 0;
  int         lastBest, lastBx, lastBy, lastCount;

  always #5 clk = ~clk;

  harris_corner_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(10), .Y_W(10), .LAG(LAG)) dut (
    .clk(clk), .reset(reset), .clk_en(clkEn), .frame_start(frameStart),
    .harris_feature(feature), .threshold(threshold),
    .corner_flag(cornerFlag), .corner_x(cornerX), .corner_y(cornerY),
    .best_feature(bestFeature), .best_x(bestX), .best_y(bestY),
    .corner_count(cornerCount), .result_valid(resultValid), .busy(busy)
  );

  harris_corner_tracker #(.H_ACTIVE(BH), .V_ACTIVE(BV), .X_W(10), .Y_W(10), .LAG(LAG)) bigDut (
    .clk(clk), .reset(reset), .clk_en(bigClkEn), .frame_start(bigFrameStart),
    .harris_feature(bigFeature), .threshold(bigThreshold),
    .corner_flag(bigFlag), .corner_x(bigCx), .corner_y(bigCy),
    .best_feature(bigBest), .best_x(bigBx), .best_y(bigBy),
    .corner_count(bigCount), .result_valid(bigValid), .busy(bigBusy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Reference summary of the frame held in frameData, straight from the frame rules.
  function automatic resultExp_t frameSummary(input int thr);
    resultExp_t r;
    int n = 0;
    r.best = -131072; r.bx = 0; r.by = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (x >= 2*LAG && y >= 2*LAG) begin
          if (frameData[y][x] >= thr) n++;
          if (frameData[y][x] > r.best) begin
            r.best = frameData[y][x]; r.bx = x - LAG; r.by = y - LAG;
          end
        end
    r.count = (n > 65535) ? 65535 : n;
    return r;
  endfunction

  task automatic fillConst(input int v);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        frameData[y][x] = v;
  endtask

  task automatic fillRandom();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        frameData[y][x] = int'($urandom_range(0, 40)) * 50 - 1000;
  endtask

  // Streams frameData as one frame; abortRow >= 0 stops the frame at that row's start.
  task automatic applyStimulus(input int thr, input int gap, input int abortRow);
    sampleExp_t s;
    resultExp_t r;
    frameStart = 1'b1;
    clkEn      = 1'($urandom_range(0, 1));
    feature    = 18'($urandom);
    threshold  = 18'(thr);
    @(negedge clk);
    frameStart = 1'b0;
    clkEn      = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    for (int y = 0; y < V; y++) begin
      if (y == abortRow) return;
      for (int x = 0; x < H; x++) begin
        for (int g = 0; g < gap; g++) begin
          feature = 18'($urandom);
          @(negedge clk);
        end
        clkEn        = 1'b1;
        sampleStrobe = 1'b1;
        feature      = 18'(frameData[y][x]);
        s.flag = (x >= 2*LAG && y >= 2*LAG && frameData[y][x] >= thr) ? 1 : 0;
        s.x    = (x >= 2*LAG && y >= 2*LAG) ? x - LAG : 0;
        s.y    = (x >= 2*LAG && y >= 2*LAG) ? y - LAG : 0;
        sampleQ.push_back(s);
        @(negedge clk);
        clkEn        = 1'b0;
        sampleStrobe = 1'b0;
      end
    end
    r = frameSummary(thr);
    resultQ.push_back(r);
    lastBest = r.best; lastBx = r.bx; lastBy = r.by; lastCount = r.count;
  endtask

  task automatic checkSummary(input string tag, input int b, input int bx, input int by, input int c);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_best"},  int'(bestFeature), b);
    checkOutput({tag, "_bx"},    int'(bestX), bx);
    checkOutput({tag, "_by"},    int'(bestY), by);
    checkOutput({tag, "_count"}, int'(cornerCount), c);
  endtask

  // Per-sample monitor: an output is due the negedge after each consumed strobe.
  initial begin
    logic took;
    sampleExp_t e;
    forever begin
      @(posedge clk);
      took = sampleStrobe;
      @(negedge clk);
      if (took) begin
        if (sampleQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL sample_queue: actual=output required=no pending sample");
        end else begin
          e = sampleQ.pop_front();
          checkOutput("corner_flag", int'(cornerFlag), e.flag);
          checkOutput("corner_x", int'(cornerX), e.x);
          checkOutput("corner_y", int'(cornerY), e.y);
        end
      end
    end
  end

  always @(negedge clk) begin
    resultExp_t e;
    if (resultValid === 1'b1) begin
      if (resultQ.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL result_unexpected: actual=pulse required=none");
      end else begin
        e = resultQ.pop_front();
        checkOutput("best_feature", int'(bestFeature), e.best);
        checkOutput("best_x", int'(bestX), e.bx);
        checkOutput("best_y", int'(bestY), e.by);
        checkOutput("corner_count", int'(cornerCount), e.count);
      end
    end
  end

  always @(negedge clk) begin
    resultExp_t e;
    if (bigValid === 1'b1) begin
      if (bigQ.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL big_result_unexpected: actual=pulse required=none");
      end else begin
        e = bigQ.pop_front();
        checkOutput("big_best", int'(bigBest), e.best);
        checkOutput("big_bx", int'(bigBx), e.bx);
        checkOutput("big_by", int'(bigBy), e.by);
        checkOutput("big_count", int'(bigCount), e.count);
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    resultExp_t br;
    int n;
    logic signed [17:0] v;
    reset = 1'b0; clkEn = 1'b0; frameStart = 1'b0; sampleStrobe = 1'b0;
    feature = '0; threshold = '0;
    bigClkEn = 1'b0; bigFrameStart = 1'b0; bigFeature = '0; bigThreshold = 18'sh20000;
    lastBest = 0; lastBx = 0; lastBy = 0; lastCount = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_best", int'(bestFeature), 0);
    checkOutput("reset_flag", int'(cornerFlag), 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single strong corner");
    fillConst(0);
    frameData[4][5] = 500;
    applyStimulus(100, 0, -1);
    checkSummary("t1", 500, 3, 2, 1);

    $display("[TB] tie keeps first occurrence");
    frameData[5][6] = 500;
    applyStimulus(100, 0, -1);
    checkSummary("t2", 500, 3, 2, 2);

    $display("[TB] out-of-region peak, negative threshold");
    fillConst(-7);
    frameData[5][1] = 900;
    applyStimulus(-10, 0, -1);
    checkSummary("t3", -7, 2, 2, 8);

    $display("[TB] abandoned frame");
    fillRandom();
    applyStimulus(50, 0, 3);
    checkOutput("abort_best", int'(bestFeature), lastBest);
    checkOutput("abort_count", int'(cornerCount), lastCount);
    fillRandom();
    applyStimulus(50, 1, -1);

    $display("[TB] random back-to-back frames");
    for (int k = 0; k < 6; k++) begin
      fillRandom();
      applyStimulus(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 2)), -1);
    end
    repeat (3) @(negedge clk);

    $display("[TB] gapless versus sparse strobe");
    fillRandom();
    applyStimulus(0, 0, -1);
    applyStimulus(0, 3, -1);
    repeat (3) @(negedge clk);

    $display("[TB] reset mid-frame");
    fillRandom();
    applyStimulus(0, 0, 3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_flag", int'(cornerFlag), 0);
      checkOutput("rst_cx", int'(cornerX), 0);
      checkOutput("rst_cy", int'(cornerY), 0);
      checkOutput("rst_best", int'(bestFeature), 0);
      checkOutput("rst_bx", int'(bestX), 0);
      checkOutput("rst_by", int'(bestY), 0);
      checkOutput("rst_count", int'(cornerCount), 0);
      checkOutput("rst_valid", int'(resultValid), 0);
      checkOutput("rst_busy", int'(busy), 0);
    end
    reset = 1'b1;
    lastBest = 0; lastBx = 0; lastBy = 0; lastCount = 0;
    clkEn = 1'b1; feature = 18'sd5000; threshold = '0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_flag", int'(cornerFlag), 0);
      checkOutput("idle_busy", int'(busy), 0);
    end
    clkEn = 1'b0;
    fillRandom();
    applyStimulus(-200, 0, -1);
    repeat (3) @(negedge clk);

    $display("[TB] count saturation on large raster");
    br.best = -131072; br.bx = 0; br.by = 0; n = 0;
    bigFrameStart = 1'b1;
    @(negedge clk);
    bigFrameStart = 1'b0;
    for (int y = 0; y < BV; y++)
      for (int x = 0; x < BH; x++) begin
        v = 18'($urandom);
        bigClkEn   = 1'b1;
        bigFeature = v;
        if (x >= 2*LAG && y >= 2*LAG) begin
          n++;
          if (int'(v) > br.best) begin
            br.best = int'(v); br.bx = x - LAG; br.by = y - LAG;
          end
        end
        @(negedge clk);
      end
    bigClkEn = 1'b0;
    br.count = (n > 65535) ? 65535 : n;
    bigQ.push_back(br);
    repeat (4) @(negedge clk);

    checkOutput("result_queue_drained", resultQ.size(), 0);
    checkOutput("big_queue_drained", bigQ.size(), 0);
    checkOutput("sample_queue_drained", sampleQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
